// File: rtl/alu_multicycle_exec_if.sv
// alu_multicycle_exec_if: start/done request and result bus of the execute stage
interface alu_multicycle_exec_if #(parameter int XLEN = 32);
  logic            start;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            branch_cond;
  logic            illegal_op;
  modport master (output start, alu_op, op_a, op_b, input busy, done, result, branch_cond, illegal_op);
  modport slave (input start, alu_op, op_a, op_b, output busy, done, result, branch_cond, illegal_op);
endinterface

// File: rtl/alu_multicycle_exec.sv
// alu_multicycle_exec: RV32I execute stage, single-cycle ALU ops plus iterative shifts
module alu_multicycle_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic clk,
  input  logic reset_n,
  alu_multicycle_exec_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);
  state_t          state, state_n;
  logic [XLEN-1:0] wreg, shifted, alu_res, result;
  logic [4:0]      rem, k, shamt;
  logic [1:0]      sop;
  logic            alu_br, alu_ill, branch_cond, illegal_op;
  logic            is_shift, accept, rem_done, eq, lt, ltu;
  assign shamt    = bus.op_b[4:0];
  assign is_shift = bus.alu_op == 5'b01101 || bus.alu_op == 5'b01010 || bus.alu_op == 5'b01011;
  assign accept   = bus.start && state != SHIFT;
  assign k        = rem < STEP ? rem : STEP;
  assign rem_done = rem <= STEP;
  assign eq       = bus.op_a == bus.op_b;
  assign lt       = $signed(bus.op_a) < $signed(bus.op_b);
  assign ltu      = bus.op_a < bus.op_b;
  assign bus.busy        = state == SHIFT;
  assign bus.done        = state == DONE;
  assign bus.result      = result;
  assign bus.branch_cond = branch_cond;
  assign bus.illegal_op  = illegal_op;
  // single-cycle ALU; branch codes report their condition as both flag and result
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_op)
      5'b00000: alu_res = bus.op_a + bus.op_b;
      5'b00001: alu_res = bus.op_a - bus.op_b;
      5'b00010: alu_res = bus.op_a & bus.op_b;
      5'b00011: alu_res = bus.op_a | bus.op_b;
      5'b00110: alu_res = bus.op_a ^ bus.op_b;
      5'b01000: alu_res = bus.op_b;
      5'b01101, 5'b01010, 5'b01011: alu_res = bus.op_a;
      5'b10110: alu_res = XLEN'(lt);
      5'b10111: alu_res = XLEN'(ltu);
      5'b10000: alu_br = eq;
      5'b10001: alu_br = !eq;
      5'b10010: alu_br = lt;
      5'b10011: alu_br = !lt;
      5'b10100: alu_br = ltu;
      5'b10101: alu_br = !ltu;
      default:  alu_ill = 1'b1;
    endcase
    if (alu_br) alu_res = XLEN'(1'b1);
  end
  // one shift step of k<=SHIFT_STEP bits, selected among constant shifts so no barrel shifter is built
  always_comb begin
    shifted = wreg;
    for (int i = 1; i <= SHIFT_STEP; i++)
      if (k == 5'(i))
        shifted = sop == 2'b01 ? wreg << i : sop == 2'b10 ? wreg >> i : XLEN'($signed(wreg) >>> i);
  end
  // next state: shifts with nonzero shamt iterate in SHIFT, everything else lands in DONE
  always_comb begin
    state_n = state == SHIFT ? (rem_done ? DONE : SHIFT)
            : accept ? (is_shift && shamt != 5'd0 ? SHIFT : DONE) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  // datapath: outputs update only on the edge entering DONE, shift operands latch on entry to SHIFT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wreg        <= '0;
      rem         <= '0;
      sop         <= '0;
      result      <= '0;
      branch_cond <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (accept && is_shift && shamt != 5'd0) begin
      wreg <= bus.op_a;
      rem  <= shamt;
      sop  <= bus.alu_op[1:0];
    end else if (accept) begin
      result      <= alu_res;
      branch_cond <= alu_br;
      illegal_op  <= alu_ill;
    end else if (state == SHIFT) begin
      wreg <= shifted;
      rem  <= rem - k;
      if (rem_done) begin
        result      <= shifted;
        branch_cond <= 1'b0;
        illegal_op  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_multicycle_exec.sv
// tb_alu_multicycle_exec: directed scoreboard bench for the execute stage
module tb_alu_multicycle_exec;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  alu_multicycle_exec_if #(.XLEN(32)) bus ();
  alu_multicycle_exec_if #(.XLEN(32)) bus4 ();
  alu_multicycle_exec #(.XLEN(32), .SHIFT_STEP(1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  alu_multicycle_exec #(.XLEN(32), .SHIFT_STEP(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4.slave));
  typedef struct {
    logic [31:0] res;
    logic        br;
    logic        ill;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // every done pulse retires the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus.done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'(bus.done), 32'd0);
      else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("branch_cond", 32'(bus.branch_cond), 32'(e.br));
        chk("illegal_op", 32'(bus.illegal_op), 32'(e.ill));
      end
    end
  end
  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic eb, input logic ei, input int elat);
    int lat;
    bus.start = 1'b1;
    bus.alu_op = op;
    bus.op_a = a;
    bus.op_b = b;
    sb.push_back('{er, eb, ei});
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    int d;
    bus.start = 1'b0; bus.alu_op = '0; bus.op_a = '0; bus.op_b = '0;
    bus4.start = 1'b0; bus4.alu_op = '0; bus4.op_a = '0; bus4.op_b = '0;
    #2;
    chk("rst_result", bus.result, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_flags", {30'd0, bus.branch_cond, bus.illegal_op}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    run("add", 5'b00000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0, 1);
    @(negedge clk);
    chk("hold_done_low", 32'(bus.done), 32'd0);
    chk("hold_result", bus.result, 32'h80000000);
    run("sra4", 5'b01011, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 5);
    bus4.start = 1'b1; bus4.alu_op = 5'b01011; bus4.op_a = 32'h80000000; bus4.op_b = 32'd4;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus4.done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("sra4_step4_latency", 32'(lat), 32'd2);
    chk("sra4_step4_result", bus4.result, 32'hF8000000);
    run("blt", 5'b10010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b1, 1'b0, 1);
    run("bltu", 5'b10100, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    run("beq", 5'b10000, 32'h1234, 32'h1234, 32'd1, 1'b1, 1'b0, 1);
    run("bge", 5'b10011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    run("slt", 5'b10110, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    run("sltu", 5'b10111, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    run("sub", 5'b00001, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
    run("lui", 5'b01000, 32'h1, 32'hABCDE000, 32'hABCDE000, 1'b0, 1'b0, 1);
    run("sll0", 5'b01101, 32'hDEADBEEF, 32'h20, 32'hDEADBEEF, 1'b0, 1'b0, 1);
    run("sll31", 5'b01101, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0, 32);
    bus.start = 1'b1; bus.alu_op = 5'b01010; bus.op_a = 32'hF0000000; bus.op_b = 32'd8;
    sb.push_back('{32'h00F00000, 1'b0, 1'b0});
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 chk("srl_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1; bus.alu_op = 5'b00000; bus.op_a = 32'd0; bus.op_b = 32'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 3;
    @(negedge clk);
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("srl_latency", 32'(lat), 32'd9);
    bus.start = 1'b1; bus.alu_op = 5'b01010; bus.op_a = 32'hF0000000; bus.op_b = 32'd8;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_result", bus.result, 32'd0);
    chk("abort_busy_low", 32'(bus.busy), 32'd0);
    chk("abort_done_low", 32'(bus.done), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    d = 0;
    repeat (12) begin
      @(negedge clk);
      d += int'(bus.done);
    end
    chk("abort_no_done", 32'(d), 32'd0);
    run("illegal", 5'b11111, 32'h55, 32'h66, 32'd0, 1'b0, 1'b1, 1);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_op = 5'b00000; bus.op_a = 32'd5; bus.op_b = 32'd7;
    sb.push_back('{32'd12, 1'b0, 1'b0});
    @(posedge clk);
    #1 bus.alu_op = 5'b00110; bus.op_a = 32'hFF00FF00; bus.op_b = 32'h0F0F0F0F;
    sb.push_back('{32'hF00FF00F, 1'b0, 1'b0});
    @(negedge clk);
    chk("b2b_done1", 32'(bus.done), 32'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_done2", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("b2b_done_drop", 32'(bus.done), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
